// File: rtl/ccd_phase_sequencer_pkg.sv
//==============================================================================
// Module  : ccd_seq_pkg
// Brief   : Shared types and quarter-length helper for the CCD phase sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

package ccd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRECHG = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic [1:0] quarter_t;

    localparam int unsigned FSEL_MAX = 15;

    // Quarter length in clocks, with the select clamped up to fsel_min.
    function automatic logic [15:0] q_len(input logic [3:0] f_select,
                                          input int unsigned fsel_min);
        logic [3:0] eff;
        eff = (32'(f_select) < fsel_min) ? 4'(fsel_min) : f_select;
        return 16'd1 << eff;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccd_phase_sequencer_if.sv
//==============================================================================
// Module  : ccd_phase_sequencer_if
// Brief   : Control/status and clock-phase bundle; abort exists only when
//           CCD_PHASE_SEQ_ABORT_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface ccd_phase_sequencer_if #(
    parameter int unsigned PIX_W = 12
);
    logic             start;
    logic [3:0]       f_select;
    logic [PIX_W-1:0] n_pixels;
`ifdef CCD_PHASE_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [PIX_W-1:0] pix_cnt;
    logic             phi_p;
    logic             phi_l1;
    logic             phi_l2;
    logic             phi_r;

    modport master (
        output start, f_select, n_pixels,
`ifdef CCD_PHASE_SEQ_ABORT_EN
        output abort,
`endif
        input  busy, done, pix_cnt, phi_p, phi_l1, phi_l2, phi_r
    );

    modport slave (
        input  start, f_select, n_pixels,
`ifdef CCD_PHASE_SEQ_ABORT_EN
        input  abort,
`endif
        output busy, done, pix_cnt, phi_p, phi_l1, phi_l2, phi_r
    );

endinterface

`default_nettype wire

// File: rtl/ccd_phase_sequencer_quarter_timer.sv
//==============================================================================
// Module  : ccd_quarter_timer
// Brief   : Counts Q-cycle quarters; emits tick, quarter index and dead window.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ccd_quarter_timer
    import ccd_seq_pkg::*;
#(
    parameter int unsigned FSEL_MIN = 2,
    parameter int unsigned DEAD_CYC = 1
) (
    input  wire logic       start_clk,
    input  wire logic       rst,
    input  wire logic       clear,
    input  wire logic [3:0] f_sel,
    output logic            quarter_tick,
    output quarter_t        quarter,
    output logic            dead
);

    logic [14:0] r_cnt;
    quarter_t    r_quarter;
    logic [15:0] w_q_last;

    assign w_q_last     = q_len(f_sel, FSEL_MIN) - 16'd1;
    assign quarter_tick = ({1'b0, r_cnt} == w_q_last);
    assign dead         = ({17'd0, r_cnt} < DEAD_CYC);
    assign quarter      = r_quarter;

    always_ff @(posedge start_clk) begin
        if (rst || clear) begin
            r_cnt     <= '0;
            r_quarter <= '0;
        end else if (quarter_tick) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt + 15'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ccd_phase_sequencer.sv
//==============================================================================
// Module  : ccd_phase_sequencer
// Brief   : Frame-based CCD clock-phase generator (precharge, N pixel shifts,
//           done). Optional abort input under CCD_PHASE_SEQ_ABORT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ccd_phase_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int unsigned PIX_W    = 12,
    parameter int unsigned FSEL_MIN = 2,
    parameter int unsigned DEAD_CYC = 1
) (
    input  wire logic               start_clk,
    input  wire logic               rst,
    ccd_phase_sequencer_if.slave    bus
);

    localparam logic [1:0] c_st_idle   = IDLE;
    localparam logic [1:0] c_st_prechg = PRECHG;
    localparam logic [1:0] c_st_shift  = SHIFT;
    localparam logic [1:0] c_st_done   = DONE;

    generate
        if (DEAD_CYC >= (32'd1 << FSEL_MIN)) begin : g_dead_chk
            $error("DEAD_CYC must be smaller than the minimum quarter length");
        end
        if (FSEL_MIN > FSEL_MAX) begin : g_fsel_chk
            $error("FSEL_MIN exceeds FSEL_MAX");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [3:0]       r_fsel;
    logic [PIX_W-1:0] r_npix;
    logic [PIX_W-1:0] r_pix;
    logic             r_abort_pend;

    logic             w_abort;
    logic             w_end_req;
    logic             w_tick;
    logic             w_dead;
    logic             w_clear;
    logic             w_shift;
    quarter_t         w_qtr;

`ifdef CCD_PHASE_SEQ_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // A same-cycle abort counts too, so an abort landing on a boundary is not lost.
    assign w_end_req = r_abort_pend | w_abort;
    assign w_shift   = (r_state == c_st_shift);
    assign w_clear   = (r_state == c_st_idle) || (r_state == c_st_done) ||
                       ((r_state == c_st_prechg) && w_tick);

    ccd_quarter_timer #(
        .FSEL_MIN (FSEL_MIN),
        .DEAD_CYC (DEAD_CYC)
    ) u_timer (
        .start_clk    (start_clk),
        .rst          (rst),
        .clear        (w_clear),
        .f_sel        (r_fsel),
        .quarter_tick (w_tick),
        .quarter      (w_qtr),
        .dead         (w_dead)
    );

    always_ff @(posedge start_clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_fsel       <= '0;
            r_npix       <= '0;
            r_pix        <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_fsel       <= bus.f_select;
                        r_npix       <= bus.n_pixels;
                        r_pix        <= '0;
                        r_abort_pend <= 1'b0;
                        r_state      <= c_st_prechg;
                    end
                end
                c_st_prechg: begin
                    if (w_abort) r_abort_pend <= 1'b1;
                    if (w_tick) begin
                        r_state <= ((r_npix == '0) || w_end_req) ? c_st_done : c_st_shift;
                    end
                end
                c_st_shift: begin
                    if (w_abort) r_abort_pend <= 1'b1;
                    if (w_tick && (w_qtr == 2'd3)) begin
                        if ((r_pix == r_npix - PIX_W'(1)) || w_end_req) begin
                            r_state <= c_st_done;
                        end else begin
                            r_pix <= r_pix + PIX_W'(1);
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    // Outputs are a registered decode of the state/timer, one cycle behind.
    always_ff @(posedge start_clk) begin
        if (rst) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.pix_cnt <= '0;
            bus.phi_p   <= 1'b0;
            bus.phi_l1  <= 1'b0;
            bus.phi_l2  <= 1'b0;
            bus.phi_r   <= 1'b0;
        end else begin
            bus.busy    <= (r_state != c_st_idle);
            bus.done    <= (r_state == c_st_done);
            bus.pix_cnt <= r_pix;
            bus.phi_p   <= (r_state == c_st_prechg);
            bus.phi_r   <= w_shift && (w_qtr == 2'd0);
            bus.phi_l2  <= w_shift && (((w_qtr == 2'd0) && !w_dead) || (w_qtr == 2'd1));
            bus.phi_l1  <= w_shift && (((w_qtr == 2'd2) && !w_dead) || (w_qtr == 2'd3));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ccd_phase_sequencer.sv
//==============================================================================
// Module  : tb_ccd_phase_sequencer
// Brief   : Scoreboard bench: stimulus queues expected output vectors per cycle,
//           monitor pops and compares. Abort cases need CCD_PHASE_SEQ_ABORT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ccd_phase_sequencer;

    localparam int PIX_W    = 12;
    localparam int FSEL_MIN = 2;
    localparam int DEAD_CYC = 1;

    logic start_clk = 1'b0;
    logic rst       = 1'b1;

    ccd_phase_sequencer_if #(.PIX_W(PIX_W)) bus();

    ccd_phase_sequencer #(
        .PIX_W    (PIX_W),
        .FSEL_MIN (FSEL_MIN),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .start_clk (start_clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 start_clk = ~start_clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [PIX_W-1:0] pix;
        logic             p;
        logic             l1;
        logic             l2;
        logic             r;
    } vec_t;

    vec_t exp_q[$];
    vec_t got;
    vec_t expv;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   last_pix = 0;

    function automatic vec_t idle_vec(input int pix);
        vec_t v;
        v     = '0;
        v.pix = PIX_W'(pix);
        return v;
    endfunction

    // Output seen in the cycle t clocks after the accepting edge of a frame.
    function automatic vec_t model(input int t, input int q, input int n, input int last);
        vec_t v;
        int   t_done, u, w, qd, off;
        v      = '0;
        t_done = q + 4 * q * n + 1;
        if (t == 0) begin
            v.pix = PIX_W'(last);
        end else if (t <= q) begin
            v.busy = 1'b1;
            v.p    = 1'b1;
        end else if (t < t_done) begin
            u      = t - q - 1;
            w      = u % (4 * q);
            qd     = w / q;
            off    = w % q;
            v.busy = 1'b1;
            v.pix  = PIX_W'(u / (4 * q));
            v.r    = (qd == 0);
            v.l2   = ((qd == 0) && (off >= DEAD_CYC)) || (qd == 1);
            v.l1   = ((qd == 2) && (off >= DEAD_CYC)) || (qd == 3);
        end else begin
            v.pix  = PIX_W'((n == 0) ? 0 : n - 1);
            v.busy = (t == t_done);
            v.done = (t == t_done);
        end
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge start_clk);
            #1;
            got = {bus.busy, bus.done, bus.pix_cnt, bus.phi_p, bus.phi_l1, bus.phi_l2, bus.phi_r};
            if (exp_q.size() != 0) begin
                expv  = exp_q.pop_front();
                n_vec = n_vec + 1;
                if (got !== expv) begin
                    n_err = n_err + 1;
                    $display("FAIL outputs @%0t got busy=%b done=%b pix=%0d p=%b l1=%b l2=%b r=%b exp busy=%b done=%b pix=%0d p=%b l1=%b l2=%b r=%b",
                             $time, got.busy, got.done, got.pix, got.p, got.l1, got.l2, got.r,
                             expv.busy, expv.done, expv.pix, expv.p, expv.l1, expv.l2, expv.r);
                end
                n_vec = n_vec + 1;
                if (bus.phi_l1 === 1'b1 && bus.phi_l2 === 1'b1) begin
                    n_err = n_err + 1;
                    $display("FAIL overlap @%0t phi_l1=1 phi_l2=1 exp not both high", $time);
                end
            end
        end
    end

    task automatic idle_cycles(input int k);
        repeat (k) begin
            exp_q.push_back(idle_vec(last_pix));
            @(negedge start_clk);
        end
    endtask

    // Entered and left on a negedge with the expectation queue empty.
    task automatic run_frame(input int fsel, input int n, input int abort_at,
                             input int rst_at, input bit pulses);
        int q, eff, n_eff, e, t_done, budget;
        bit rst_rel;
        eff   = (fsel < FSEL_MIN) ? FSEL_MIN : fsel;
        q     = 1 << eff;
        n_eff = n;
        if (abort_at > 0) begin
            e = abort_at - 1;
            if (e < q)                  n_eff = 0;
            else if (e < q + 4 * q * n) n_eff = (e - q) / (4 * q) + 1;
        end
        t_done = q + 4 * q * n_eff + 1;
        bus.start    = 1'b1;
        bus.f_select = 4'(fsel);
        bus.n_pixels = PIX_W'(n);
        for (int t = 0; t <= t_done + 1; t++) exp_q.push_back(model(t, q, n_eff, last_pix));
        last_pix = (n_eff == 0) ? 0 : n_eff - 1;
        budget   = t_done + 20;
        rst_rel  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge start_clk);
            bus.start    = pulses && (i == 9 || i == 29);
            bus.f_select = 4'($urandom_range(0, 15));
            bus.n_pixels = PIX_W'($urandom);
`ifdef CCD_PHASE_SEQ_ABORT_EN
            bus.abort    = (abort_at > 0) && (i == abort_at - 1);
`endif
            if (rst_rel) begin
                rst     = 1'b0;
                rst_rel = 1'b0;
                exp_q.push_back(idle_vec(0));
            end else if (rst_at > 0 && i == rst_at - 1) begin
                rst      = 1'b1;
                rst_rel  = 1'b1;
                last_pix = 0;
                exp_q.delete();
                exp_q.push_back(idle_vec(0));
            end
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL frame_timeout fsel=%0d n=%0d pending=%0d exp 0", fsel, n, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fs, np, ab, qq;
        bus.start    = 1'b0;
        bus.f_select = 4'd0;
        bus.n_pixels = '0;
`ifdef CCD_PHASE_SEQ_ABORT_EN
        bus.abort    = 1'b0;
`endif
        rst = 1'b1;
        @(negedge start_clk);
        exp_q.push_back(idle_vec(0));
        @(negedge start_clk);
        rst = 1'b0;
        exp_q.push_back(idle_vec(0));
        @(negedge start_clk);

        run_frame(2, 3, 0, 0, 1'b1);   // basic frame with ignored start pulses
        idle_cycles(3);
        run_frame(0, 0, 0, 0, 1'b0);   // clamped select, zero pixels
        run_frame(5, 10, 0, 0, 1'b0);
        idle_cycles(2);
        run_frame(2, 3, 0, 30, 1'b0);  // reset lands in pixel 1 q2
        run_frame(2, 2, 0, 0, 1'b0);
        run_frame(2, 1, 0, 0, 1'b0);
`ifdef CCD_PHASE_SEQ_ABORT_EN
        run_frame(2, 8, 22, 0, 1'b0);
        run_frame(3, 4, 3, 0, 1'b0);
`endif
        for (int k = 0; k < 12; k++) begin
            fs = $urandom_range(0, 4);
            np = $urandom_range(0, 6);
            ab = 0;
`ifdef CCD_PHASE_SEQ_ABORT_EN
            qq = 1 << ((fs < FSEL_MIN) ? FSEL_MIN : fs);
            if ($urandom_range(0, 1) == 1) ab = $urandom_range(1, qq + 4 * qq * np + 2);
`else
            qq = 0;
`endif
            run_frame(fs, np, ab, 0, 1'b0);
            idle_cycles($urandom_range(0, 4));
        end
        idle_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
